jtframe_dump_ctrl: RTL and testbench

- Synthesizable scheduler that decides when a waveform/trace capture window is open.
- Counts video frames on the falling edge of vertical sync and tracks the ROM-download phase.
- Opens a capture window either at a programmed frame number or at the end of a download. Closes it after a programmed number of frames.
- Sits beside the game core in simulation and debug builds. Its outputs gate the dump tasks or an on-chip trace buffer.

---
 rtl/jtframe_dump_ctrl.sv | 132 +++++++++++++
 tb/tb_jtframe_dump_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dump_ctrl.sv
// Capture-window scheduler: counts frames on vsync falling edges and opens a dump
// window at a programmed frame or at the end of a ROM download, closing it after N frames.
module jtframe_dump_ctrl #(
  parameter int FCW     = 32,
  parameter int LCW     = 16,
  parameter int DL_MIN  = 20000,
  parameter int AUTOARM = 1
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           vs,
  input  logic           downloading,
  input  logic           arm,
  input  logic           cfg_dlmode,
  input  logic [FCW-1:0] cfg_start,
  input  logic [LCW-1:0] cfg_len,
  output logic [FCW-1:0] frame_cnt,
  output logic           dump_on,
  output logic           dump_start,
  output logic           dump_stop,
  output logic [2:0]     st
);

  localparam int CCW = (DL_MIN > 0) ? $clog2(DL_MIN + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    ACTIVE = 3'd2,
    DONE   = 3'd3
  } state_t;

  state_t state, state_nx;

  logic           vs_l, dl_l, fresh;
  logic [CCW-1:0] cyc_cnt;
  logic [LCW-1:0] len_cnt;
  logic           mode_q;
  logic [FCW-1:0] start_q;
  logic [LCW-1:0] len_q;
  logic           vs_fall, dl_fall, dl_rise, dl_ok;
  logic           load_cfg, open_win, close_win;

  assign vs_fall = vs_l & ~vs;
  assign dl_fall = dl_l & ~downloading;
  assign dl_rise = ~dl_l & downloading;
  assign dl_ok   = (cyc_cnt == CCW'(DL_MIN));
  assign st      = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // An arm pulse in ARMED takes priority over a coincident start: it only reloads config.
  always_comb begin
    state_nx  = state;
    load_cfg  = 1'b0;
    open_win  = 1'b0;
    close_win = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm || (fresh && (AUTOARM != 0))) begin
          load_cfg = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (arm) begin
          load_cfg = 1'b1;
        end else if (mode_q ? (dl_fall && dl_ok)
                            : (vs_fall && !downloading && frame_cnt >= start_q)) begin
          open_win = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (dl_rise) begin
          close_win = 1'b1;
          state_nx  = mode_q ? ARMED : DONE;
        end else if (vs_fall && len_q != '0 && LCW'(len_cnt + 1'b1) == len_q) begin
          close_win = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (arm) begin
          load_cfg = 1'b1;
          state_nx = ARMED;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l       <= 1'b0;
      dl_l       <= 1'b0;
      fresh      <= 1'b1;
      cyc_cnt    <= '0;
      frame_cnt  <= '0;
      len_cnt    <= '0;
      mode_q     <= 1'b0;
      start_q    <= '0;
      len_q      <= '0;
      dump_on    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      vs_l  <= vs;
      dl_l  <= downloading;
      fresh <= 1'b0;
      if (!dl_ok) cyc_cnt <= cyc_cnt + 1'b1;
      // frame count restarts at the end of every download
      if (downloading || dl_fall) frame_cnt <= '0;
      else if (vs_fall)           frame_cnt <= frame_cnt + 1'b1;
      if (load_cfg) begin
        mode_q  <= cfg_dlmode;
        start_q <= cfg_start;
        len_q   <= cfg_len;
      end
      if (open_win)                      len_cnt <= '0;
      else if (state == ACTIVE && vs_fall) len_cnt <= len_cnt + 1'b1;
      dump_start <= open_win;
      dump_stop  <= close_win;
      if (open_win)       dump_on <= 1'b1;
      else if (close_win) dump_on <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Bench for jtframe_dump_ctrl: event-level model compared every cycle, plus directed
// scenarios with hand-computed frame numbers and timings.
module tb_jtframe_dump_ctrl;

  localparam int FCW    = 8;
  localparam int LCW    = 6;
  localparam int DL_MIN = 100;

  logic           clk = 1'b0;
  logic           rst, vs, downloading, arm, cfg_dlmode;
  logic [FCW-1:0] cfg_start;
  logic [LCW-1:0] cfg_len;
  logic [FCW-1:0] frame_cnt;
  logic           dump_on, dump_start, dump_stop;
  logic [2:0]     st;

  jtframe_dump_ctrl #(.FCW(FCW), .LCW(LCW), .DL_MIN(DL_MIN), .AUTOARM(1)) dut (
    .clk(clk), .rst(rst), .vs(vs), .downloading(downloading), .arm(arm),
    .cfg_dlmode(cfg_dlmode), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .frame_cnt(frame_cnt), .dump_on(dump_on), .dump_start(dump_start),
    .dump_stop(dump_stop), .st(st)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  // Model: phase names 0 idle, 1 waiting for trigger, 2 window open, 3 finished.
  int m_phase, m_frames, m_len, m_age, m_start, m_limit;
  bit m_open, m_pstart, m_pstop, m_prev_vs, m_prev_dl, m_first, m_dlmode, m_valid = 0;

  always @(posedge clk) begin
    bit frame_tick, dl_end, dl_begin, opened, closed;
    if (rst) begin
      m_phase = 0; m_frames = 0; m_len = 0; m_age = 0; m_start = 0; m_limit = 0;
      m_open = 0; m_pstart = 0; m_pstop = 0; m_prev_vs = 0; m_prev_dl = 0;
      m_first = 1; m_dlmode = 0; m_valid = 1;
    end else begin
      frame_tick = m_prev_vs && !vs;
      dl_end     = m_prev_dl && !downloading;
      dl_begin   = !m_prev_dl && downloading;
      opened = 0; closed = 0;
      if ((m_phase == 0 && (arm || m_first)) || ((m_phase == 1 || m_phase == 3) && arm)) begin
        m_dlmode = cfg_dlmode; m_start = int'(cfg_start); m_limit = int'(cfg_len);
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_dlmode ? (dl_end && m_age >= DL_MIN)
                     : (frame_tick && !downloading && m_frames >= m_start)) begin
          opened = 1; m_phase = 2; m_len = 0;
        end
      end else if (m_phase == 2) begin
        if (dl_begin) begin
          closed = 1; m_phase = m_dlmode ? 1 : 3;
        end else if (frame_tick) begin
          m_len = (m_len + 1) % (1 << LCW);
          if (m_limit != 0 && m_len == m_limit) begin
            closed = 1; m_phase = 3;
          end
        end
      end
      if (downloading || dl_end) m_frames = 0;
      else if (frame_tick)      m_frames = (m_frames + 1) % (1 << FCW);
      if (m_age < DL_MIN) m_age++;
      m_pstart = opened; m_pstop = closed;
      if (opened) m_open = 1;
      if (closed) m_open = 0;
      m_prev_vs = vs; m_prev_dl = downloading; m_first = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("frame_cnt", int'(frame_cnt), m_frames);
      cmp("dump_on", int'(dump_on), int'(m_open));
      cmp("dump_start", int'(dump_start), int'(m_pstart));
      cmp("dump_stop", int'(dump_stop), int'(m_pstop));
      cmp("st", int'(st), m_phase);
    end
  end

  int n_start, n_stop, start_fc, stop_fc, start_t, stop_t;
  always @(negedge clk) begin
    if (dump_start) begin n_start++; start_fc = int'(frame_cnt); start_t = tcyc; end
    if (dump_stop)  begin n_stop++;  stop_fc  = int'(frame_cnt); stop_t  = tcyc; end
  end

  task automatic clr_watch();
    n_start = 0; n_stop = 0; start_fc = -1; stop_fc = -1; start_t = -1; stop_t = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vs = 1'b1; tick(2);
    vs = 1'b0; tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(3);
    cmp("rst frame_cnt", int'(frame_cnt), 0);
    cmp("rst dump_on", int'(dump_on), 0);
    cmp("rst st", int'(st), 0);
    rst = 1'b0; tick(1);
    cmp("autoarm st", int'(st), 1);
    clr_watch();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_t;
    rst = 1'b1; vs = 1'b0; downloading = 1'b0; arm = 1'b0;
    cfg_dlmode = 1'b0; cfg_start = 8'd5; cfg_len = 6'd3;
    clr_watch();

    // frame mode: opens at frame 5 (count 6), closes 3 frames later
    do_reset();
    repeat (10) frame();
    cmp("fm starts", n_start, 1);
    cmp("fm start fc", start_fc, 6);
    cmp("fm stops", n_stop, 1);
    cmp("fm stop fc", stop_fc, 9);
    cmp("fm window cycles", stop_t - start_t, 12);
    cmp("fm st done", int'(st), 3);

    // download mode: early download ignored, later one opens the window
    cfg_dlmode = 1'b1; cfg_start = 8'd0; cfg_len = 6'd0;
    do_reset();
    tick(9); downloading = 1'b1; tick(40); downloading = 1'b0; tick(5);
    cmp("dl early starts", n_start, 0);
    cmp("dl early fc", int'(frame_cnt), 0);
    cmp("dl early st", int'(st), 1);
    tick(145); downloading = 1'b1; tick(200); downloading = 1'b0;
    rel_t = tcyc; tick(3);
    cmp("dl starts", n_start, 1);
    cmp("dl start time", start_t, rel_t + 1);
    cmp("dl start fc", start_fc, 0);
    frame();
    cmp("dl fc after vs", int'(frame_cnt), 1);

    // unbounded window across length and frame counter wrap
    cfg_dlmode = 1'b0; cfg_start = 8'd0; cfg_len = 6'd0;
    do_reset();
    repeat (600) frame();
    cmp("ub starts", n_start, 1);
    cmp("ub start fc", start_fc, 1);
    cmp("ub stops", n_stop, 0);
    cmp("ub dump_on", int'(dump_on), 1);
    cmp("ub fc wrap", int'(frame_cnt), 600 % 256);

    // abort by download start in frame mode
    cfg_start = 8'd1; cfg_len = 6'd0;
    do_reset();
    repeat (3) frame();
    cmp("ab open", int'(dump_on), 1);
    downloading = 1'b1; tick(1);
    cmp("ab stop pulse", int'(dump_stop), 1);
    cmp("ab st", int'(st), 3);
    cmp("ab fc", int'(frame_cnt), 0);
    repeat (3) frame();
    cmp("ab fc held", int'(frame_cnt), 0);
    downloading = 1'b0; tick(3);
    cmp("ab st after dl", int'(st), 3);
    arm = 1'b1; tick(1); arm = 1'b0;
    cmp("ab rearm st", int'(st), 1);

    // re-arm latches config only on the arm pulse
    cfg_start = 8'd1; cfg_len = 6'd1;
    do_reset();
    repeat (3) frame();
    cmp("ra first done", int'(st), 3);
    downloading = 1'b1; tick(5); downloading = 1'b0; tick(2);
    cmp("ra fc cleared", int'(frame_cnt), 0);
    cfg_start = 8'd2; frame();
    cmp("ra no arm st", int'(st), 3);
    clr_watch();
    cfg_start = 8'd4; cfg_len = 6'd3; arm = 1'b1; tick(1); arm = 1'b0;
    cfg_start = 8'd2; cfg_len = 6'd1;
    repeat (4) frame();
    cmp("ra start fc", start_fc, 5);
    cmp("ra active", int'(st), 2);
    arm = 1'b1; tick(1); arm = 1'b0;
    cmp("ra arm in active st", int'(st), 2);
    cmp("ra arm in active on", int'(dump_on), 1);
    repeat (3) frame();
    cmp("ra stop fc", stop_fc, 8);
    cmp("ra done", int'(st), 3);

    // reset in the middle of an open window
    cfg_start = 8'd0; cfg_len = 6'd0;
    do_reset();
    repeat (2) frame();
    cmp("rm open", int'(dump_on), 1);
    rst = 1'b1; tick(1);
    cmp("rm dump_on", int'(dump_on), 0);
    cmp("rm fc", int'(frame_cnt), 0);
    cmp("rm no stop", int'(dump_stop), 0);
    cmp("rm st", int'(st), 0);
    rst = 1'b0; tick(1);
    cmp("rm autoarm", int'(st), 1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
